// File: rtl/step_sequencer.sv
// Step sequencer: pattern memory of 12-bit note masks plus a playback timer
// that drives the audio generator's Select mask at a programmable step rate.
module step_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int SW        = 4,
  parameter int TW        = 24
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stop,
  input  logic [TW-1:0] StepPeriod,
  input  logic [TW-1:0] GateLen,
  input  logic [SW:0]   Length,
  input  logic          WrEn,
  input  logic [SW-1:0] WrAddr,
  input  logic [11:0]   WrData,
  output logic [11:0]   Select,
  output logic [SW-1:0] Step,
  output logic          StepTick,
  output logic          Running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [11:0]   pattern [NUM_STEPS];
  logic [TW-1:0] count, count_n;
  logic [SW-1:0] step_n;
  logic [11:0]   select_n;
  logic          tick_n;
  logic [TW-1:0] p_eff;
  logic [SW:0]   len_eff;
  logic [SW:0]   step_inc;

  // Effective period and length after clamping the out-of-range encodings.
  always_comb begin
    p_eff    = (StepPeriod < TW'(2)) ? TW'(2) : StepPeriod;
    len_eff  = (Length == '0 || Length > (SW+1)'(NUM_STEPS)) ? (SW+1)'(NUM_STEPS) : Length;
    step_inc = {1'b0, Step} + (SW+1)'(1);
  end

  // Stop has priority over Start; Start restarts from any state.
  always_comb begin
    state_n  = state;
    count_n  = count;
    step_n   = Step;
    select_n = '0;
    tick_n   = 1'b0;
    if (Stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (Start) begin
      state_n  = RUN;
      count_n  = '0;
      step_n   = '0;
      tick_n   = 1'b1;
      select_n = (GateLen != '0) ? pattern[0] : 12'h000;
    end else begin
      case (state)
        RUN: begin
          // >= so a shortened period fires at once instead of wrapping Count.
          if (count >= p_eff - TW'(1)) begin
            count_n = '0;
            step_n  = (step_inc >= len_eff) ? '0 : step_inc[SW-1:0];
            tick_n  = 1'b1;
          end else begin
            count_n = count + TW'(1);
          end
          select_n = (count_n < GateLen) ? pattern[step_n] : 12'h000;
        end
        default: begin
          select_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      Step     <= '0;
      Select   <= '0;
      StepTick <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      Step     <= step_n;
      Select   <= select_n;
      StepTick <= tick_n;
    end
  end

  // Pattern is read live by the playback logic, so writes show up next edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (WrEn) begin
      pattern[WrAddr] <= WrData;
    end
  end

  assign Running = (state == RUN);

endmodule
